// File: rtl/e_mdu_pkg.sv
// ---------------------------------------------------------------------------
// e_mdu_pkg -- shared definitions for the E-stage multiply/divide unit.
//   * MDU opcode constants (4-bit) driven on E_MDUOp by the decoder.
//   * FSM state type for e_mdu.
//   * Behavioural 64-bit multiply and divide helpers.
// ---------------------------------------------------------------------------
package e_mdu_pkg;

  localparam logic [3:0] MDU_NONE  = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MFHI  = 4'd5;
  localparam logic [3:0] MDU_MFLO  = 4'd6;
  localparam logic [3:0] MDU_MTHI  = 4'd7;
  localparam logic [3:0] MDU_MTLO  = 4'd8;
  localparam logic [3:0] MDU_MADD  = 4'd9;
  localparam logic [3:0] MDU_MADDU = 4'd10;
  localparam logic [3:0] MDU_MSUB  = 4'd11;
  localparam logic [3:0] MDU_MSUBU = 4'd12;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

  // 32x32->64 product. Sign-extending both operands to 64 bits and keeping
  // the low 64 bits of the product yields the two's-complement signed result.
  function automatic logic [63:0] mul64(input logic [31:0] a,
                                        input logic [31:0] b,
                                        input logic        is_signed);
    logic [63:0] ax;
    logic [63:0] bx;
    ax = is_signed ? {{32{a[31]}}, a} : {32'd0, a};
    bx = is_signed ? {{32{b[31]}}, b} : {32'd0, b};
    return ax * bx;
  endfunction

  // Returns {remainder, quotient}. Signed division truncates toward zero,
  // so the remainder carries the sign of the dividend. Caller handles b==0.
  function automatic logic [63:0] div64(input logic [31:0] a,
                                        input logic [31:0] b,
                                        input logic        is_signed);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic [31:0]        q;
    logic [31:0]        r;
    sa = a;
    sb = b;
    if (is_signed) begin
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

endpackage

// File: rtl/e_mdu.sv
// ---------------------------------------------------------------------------
// e_mdu -- E-stage multiply/divide unit with HI/LO registers.
//
// Mult/div results are computed when the op starts and held in a 64-bit
// capture register; a down-counter models the latency and the result is
// committed to HI/LO on the final busy edge.
//
// Parameters:
//   MULT_CYCLES  busy cycles for mult-class ops (default 5)
//   DIV_CYCLES   busy cycles for div-class ops  (default 10)
// Ports:
//   clk       in   clock, all state updates on posedge
//   reset     in   asynchronous active-high reset
//   E_MDUOp   in   [3:0]  opcode (e_mdu_pkg constants)
//   E_start   in   qualifies E_MDUOp as a valid, non-stalled instruction
//   E_A       in   [31:0] forwarded rs operand
//   E_B       in   [31:0] forwarded rt operand
//   E_MDUOut  out  [31:0] HI for MFHI, LO for MFLO, else 0 (combinational)
//   E_busy    out  high while a mult/div is in flight
// Build option:
//   MDU_MADD_EN  when defined, adds MADD/MADDU/MSUB/MSUBU accumulate ops.
// ---------------------------------------------------------------------------
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  E_MDUOp,
  input  logic        E_start,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  output logic [31:0] E_MDUOut,
  output logic        E_busy
);

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  mdu_state_e  state_q, state_d;
  logic [3:0]  cnt_q,   cnt_d;
  logic [31:0] hi_q,    hi_d;
  logic [31:0] lo_q,    lo_d;
  logic [63:0] res_q,   res_d;
  logic [31:0] mdu_out;

  // Next-state: op launch in IDLE, countdown and commit in BUSY.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    res_d   = res_q;
    case (state_q)
      ST_IDLE: begin
        if (E_start) begin
          case (E_MDUOp)
            MDU_MULT, MDU_MULTU: begin
              res_d   = mul64(E_A, E_B, E_MDUOp == MDU_MULT);
              cnt_d   = MULT_CNT;
              state_d = ST_BUSY;
            end
            MDU_DIV, MDU_DIVU: begin
              // Divide by zero still takes the full latency but commits the
              // current HI/LO, which cannot change while busy.
              if (E_B == 32'd0) begin
                res_d = {hi_q, lo_q};
              end else begin
                res_d = div64(E_A, E_B, E_MDUOp == MDU_DIV);
              end
              cnt_d   = DIV_CNT;
              state_d = ST_BUSY;
            end
`ifdef MDU_MADD_EN
            MDU_MADD, MDU_MADDU: begin
              res_d   = {hi_q, lo_q} + mul64(E_A, E_B, E_MDUOp == MDU_MADD);
              cnt_d   = MULT_CNT;
              state_d = ST_BUSY;
            end
            MDU_MSUB, MDU_MSUBU: begin
              res_d   = {hi_q, lo_q} - mul64(E_A, E_B, E_MDUOp == MDU_MSUB);
              cnt_d   = MULT_CNT;
              state_d = ST_BUSY;
            end
`endif
            MDU_MTHI: begin
              hi_d = E_A;
            end
            MDU_MTLO: begin
              lo_d = E_A;
            end
            default: begin
              // NONE, MFHI/MFLO and unrecognised opcodes: no state change
            end
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        // E_start is ignored here; the hazard unit stalls the instruction.
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          hi_d    = res_q[63:32];
          lo_d    = res_q[31:0];
          state_d = ST_IDLE;
        end else begin
          state_d = ST_BUSY;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // State registers; reset discards any in-flight result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      res_q   <= 64'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      res_q   <= res_d;
    end
  end

  // MFHI/MFLO read the committed registers, never the captured result.
  always_comb begin
    mdu_out = 32'd0;
    case (E_MDUOp)
      MDU_MFHI: mdu_out = hi_q;
      MDU_MFLO: mdu_out = lo_q;
      default:  mdu_out = 32'd0;
    endcase
  end

  assign E_MDUOut = mdu_out;
  assign E_busy   = (state_q == ST_BUSY);

endmodule

// File: tb/tb_e_mdu.sv
// ---------------------------------------------------------------------------
// tb_e_mdu -- self-checking bench for e_mdu: directed scenarios plus a
// randomized op stream compared against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_e_mdu;
  import e_mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  E_MDUOp = 4'd0;
  logic        E_start = 1'b0;
  logic [31:0] E_A = 32'd0;
  logic [31:0] E_B = 32'd0;
  logic [31:0] E_MDUOut;
  logic        E_busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] hi_m = 32'd0;
  logic [31:0] lo_m = 32'd0;

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .E_MDUOp(E_MDUOp), .E_start(E_start),
    .E_A(E_A), .E_B(E_B), .E_MDUOut(E_MDUOut), .E_busy(E_busy)
  );

  always #5 clk = ~clk;

  // Issue one op at (posedge + 1) and count the busy cycles that follow.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, output int nbusy);
    E_MDUOp = op; E_A = a; E_B = b; E_start = 1'b1;
    @(posedge clk); #1;
    E_start = 1'b0; E_MDUOp = MDU_NONE; E_A = 32'd0; E_B = 32'd0;
    nbusy = 0;
    while (E_busy === 1'b1 && nbusy < 40) begin
      nbusy++;
      @(posedge clk); #1;
    end
  endtask

  task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
    E_MDUOp = MDU_MFHI; #1; h = E_MDUOut;
    E_MDUOp = MDU_MFLO; #1; l = E_MDUOut;
    E_MDUOp = MDU_NONE;
  endtask

  // Reference: new {HI,LO} and latency for one op, from the arithmetic rules.
  task automatic model_op(input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, output int lat);
    longint            sa, sb, ma, mb, q, r;
    longint unsigned   ua, ub, uq, ur, acc, prod;
    logic [63:0]       v;
    lat = 0;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = longint'({32'd0, a}); ub = longint'({32'd0, b});
    acc = {hi_m, lo_m};
    case (op)
      MDU_MULT:  begin lat = 5; v = sa * sb; hi_m = v[63:32]; lo_m = v[31:0]; end
      MDU_MULTU: begin lat = 5; v = ua * ub; hi_m = v[63:32]; lo_m = v[31:0]; end
      MDU_DIV: begin
        lat = 10;
        if (b != 32'd0) begin
          ma = (sa < 0) ? -sa : sa;
          mb = (sb < 0) ? -sb : sb;
          q = ma / mb;
          if ((sa < 0) != (sb < 0)) q = -q;
          r = sa - q * sb;
          hi_m = r[31:0]; lo_m = q[31:0];
        end
      end
      MDU_DIVU: begin
        lat = 10;
        if (b != 32'd0) begin
          uq = ua / ub; ur = ua - uq * ub;
          hi_m = ur[31:0]; lo_m = uq[31:0];
        end
      end
      MDU_MTHI: hi_m = a;
      MDU_MTLO: lo_m = a;
`ifdef MDU_MADD_EN
      MDU_MADD, MDU_MSUB, MDU_MADDU, MDU_MSUBU: begin
        lat = 5;
        prod = (op == MDU_MADD || op == MDU_MSUB) ? longint'(sa * sb) : ua * ub;
        v = (op == MDU_MADD || op == MDU_MADDU) ? acc + prod : acc - prod;
        hi_m = v[63:32]; lo_m = v[31:0];
      end
`endif
      default: lat = 0;
    endcase
  endtask

  task automatic test_reset();
    logic [31:0] h, l;
    reset = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (E_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", E_busy); end
    read_hilo(h, l);
    n_checks++;
    if (h !== 32'd0 || l !== 32'd0) begin
      n_fail++; $display("FAIL reset_hilo: got %h/%h want 0/0", h, l);
    end
    reset = 1'b0;
    hi_m = 32'd0; lo_m = 32'd0;
    @(posedge clk); #1;
  endtask

  task automatic test_mult();
    int n; logic [31:0] h, l;
    run_op(MDU_MULT, 32'hFFFFFFFF, 32'd2, n);
    read_hilo(h, l);
    n_checks++;
    if (n !== 5) begin n_fail++; $display("FAIL mult_busy: got %0d want 5", n); end
    n_checks++;
    if (h !== 32'hFFFFFFFF || l !== 32'hFFFFFFFE) begin
      n_fail++; $display("FAIL mult_hilo: got %h/%h want ffffffff/fffffffe", h, l);
    end
    E_MDUOp = MDU_MULT; #1;
    n_checks++;
    if (E_MDUOut !== 32'd0) begin n_fail++; $display("FAIL out_nonmf: got %h want 0", E_MDUOut); end
    E_MDUOp = MDU_NONE;
    run_op(MDU_MULTU, 32'hFFFFFFFF, 32'd2, n);
    read_hilo(h, l);
    n_checks++;
    if (h !== 32'h1 || l !== 32'hFFFFFFFE) begin
      n_fail++; $display("FAIL multu_hilo: got %h/%h want 00000001/fffffffe", h, l);
    end
    hi_m = h; lo_m = l;
  endtask

  task automatic test_div();
    int n; logic [31:0] h, l;
    run_op(MDU_DIV, -32'sd7, 32'd2, n);
    read_hilo(h, l);
    n_checks++;
    if (n !== 10) begin n_fail++; $display("FAIL div_busy: got %0d want 10", n); end
    n_checks++;
    if (h !== 32'hFFFFFFFF || l !== 32'hFFFFFFFD) begin
      n_fail++; $display("FAIL div_hilo: got %h/%h want ffffffff/fffffffd", h, l);
    end
    run_op(MDU_DIVU, 32'd7, 32'd2, n);
    read_hilo(h, l);
    n_checks++;
    if (h !== 32'd1 || l !== 32'd3) begin
      n_fail++; $display("FAIL divu_hilo: got %h/%h want 1/3", h, l);
    end
    hi_m = h; lo_m = l;
  endtask

  task automatic test_mt_divzero();
    int n; logic [31:0] h, l;
    run_op(MDU_MTHI, 32'h1234, 32'd0, n);
    n_checks++;
    if (n !== 0) begin n_fail++; $display("FAIL mthi_busy: got %0d want 0", n); end
    run_op(MDU_MTLO, 32'h5678, 32'd0, n);
    run_op(MDU_DIV, 32'd99, 32'd0, n);
    read_hilo(h, l);
    n_checks++;
    if (n !== 10) begin n_fail++; $display("FAIL divzero_busy: got %0d want 10", n); end
    n_checks++;
    if (h !== 32'h1234 || l !== 32'h5678) begin
      n_fail++; $display("FAIL divzero_hilo: got %h/%h want 1234/5678", h, l);
    end
    hi_m = 32'h1234; lo_m = 32'h5678;
  endtask

  task automatic test_ignore_busy();
    int n; logic [31:0] h, l;
    // MULT 3*7, then MTLO in busy cycle 2
    E_MDUOp = MDU_MULT; E_A = 32'd3; E_B = 32'd7; E_start = 1'b1;
    @(posedge clk); #1;                 // busy cycle 1
    E_start = 1'b0; E_MDUOp = MDU_NONE;
    @(posedge clk); #1;                 // busy cycle 2
    E_MDUOp = MDU_MTLO; E_A = 32'hAAAA; E_start = 1'b1;
    @(posedge clk); #1;
    E_start = 1'b0; E_MDUOp = MDU_NONE;
    n = 0;
    while (E_busy === 1'b1 && n < 40) begin n++; @(posedge clk); #1; end
    read_hilo(h, l);
    n_checks++;
    if (h !== 32'd0 || l !== 32'd21) begin
      n_fail++; $display("FAIL mtlo_in_busy: got %h/%h want 0/15", h, l);
    end
    // DIVU 7/2, then MTHI on the commit cycle (busy cycle 10)
    E_MDUOp = MDU_DIVU; E_A = 32'd7; E_B = 32'd2; E_start = 1'b1;
    @(posedge clk); #1;
    E_start = 1'b0; E_MDUOp = MDU_NONE;
    for (int i = 0; i < 9; i++) begin @(posedge clk); #1; end
    n_checks++;
    if (E_busy !== 1'b1) begin n_fail++; $display("FAIL busy_c10: got %b want 1", E_busy); end
    E_MDUOp = MDU_MTHI; E_A = 32'hBEEF; E_start = 1'b1;
    @(posedge clk); #1;
    E_start = 1'b0; E_MDUOp = MDU_NONE;
    n_checks++;
    if (E_busy !== 1'b0) begin n_fail++; $display("FAIL busy_after_commit: got %b want 0", E_busy); end
    read_hilo(h, l);
    n_checks++;
    if (h !== 32'd1 || l !== 32'd3) begin
      n_fail++; $display("FAIL mthi_on_commit: got %h/%h want 1/3", h, l);
    end
    hi_m = 32'd1; lo_m = 32'd3;
  endtask

  task automatic test_reset_mid();
    int n; logic [31:0] h, l;
    run_op(MDU_MTHI, 32'hCAFE, 32'd0, n);
    run_op(MDU_MTLO, 32'hF00D, 32'd0, n);
    E_MDUOp = MDU_DIV; E_A = 32'd100; E_B = 32'd7; E_start = 1'b1;
    @(posedge clk); #1;                 // busy cycle 1
    E_start = 1'b0; E_MDUOp = MDU_NONE;
    @(posedge clk); #1;
    @(posedge clk); #1;                 // busy cycle 3
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if (E_busy !== 1'b0) begin n_fail++; $display("FAIL reset_mid_busy: got %b want 0", E_busy); end
    read_hilo(h, l);
    n_checks++;
    if (h !== 32'd0 || l !== 32'd0) begin
      n_fail++; $display("FAIL reset_mid_hilo: got %h/%h want 0/0", h, l);
    end
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (E_busy !== 1'b0) n++;
    end
    read_hilo(h, l);
    n_checks++;
    if (n !== 0 || h !== 32'd0 || l !== 32'd0) begin
      n_fail++; $display("FAIL reset_no_commit: busy_cycles %0d hilo %h/%h want 0 0/0", n, h, l);
    end
    hi_m = 32'd0; lo_m = 32'd0;
  endtask

  task automatic test_madd();
    int n, lat; logic [31:0] h, l;
    run_op(MDU_MTHI, 32'd0, 32'd0, n);
    run_op(MDU_MTLO, 32'hFFFFFFFF, 32'd0, n);
    hi_m = 32'd0; lo_m = 32'hFFFFFFFF;
    run_op(MDU_MADDU, 32'd1, 32'd1, n);
    read_hilo(h, l);
`ifdef MDU_MADD_EN
    n_checks++;
    if (n !== 5 || h !== 32'd1 || l !== 32'd0) begin
      n_fail++; $display("FAIL maddu: busy %0d hilo %h/%h want 5 1/0", n, h, l);
    end
`else
    n_checks++;
    if (n !== 0 || h !== 32'd0 || l !== 32'hFFFFFFFF) begin
      n_fail++; $display("FAIL maddu_noop: busy %0d hilo %h/%h want 0 0/ffffffff", n, h, l);
    end
`endif
    model_op(MDU_MADDU, 32'd1, 32'd1, lat);
  endtask

  task automatic test_random();
    int n, lat; logic [3:0] op; logic [31:0] a, b, h, l;
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 20));
        2: b = -32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      if (a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd3;
      model_op(op, a, b, lat);
      run_op(op, a, b, n);
      read_hilo(h, l);
      n_checks++;
      if (n !== lat) begin
        n_fail++; $display("FAIL rand_busy op=%0d: got %0d want %0d", op, n, lat);
      end
      n_checks++;
      if (h !== hi_m || l !== lo_m) begin
        n_fail++;
        $display("FAIL rand_hilo op=%0d a=%h b=%h: got %h/%h want %h/%h", op, a, b, h, l, hi_m, lo_m);
      end
    end
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_mult();
    test_div();
    test_mt_divzero();
    test_ignore_busy();
    test_reset_mid();
    test_madd();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
